// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush sequencer for the five-stage MIPS pipeline: turns hazard
// flags into PC/IF-ID/ID-EX controls, with stall watchdogs and perf counters.
module pipeline_stall_controller #(
  parameter int STALL_MAX  = 4,
  parameter int BR_TIMEOUT = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             data_hazard,
  input  logic             control_hazard,
  input  logic             branch_resolved,
  input  logic             branch_taken,
  input  logic             clr_counters,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             stall_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int CNT_MAX = (STALL_MAX > BR_TIMEOUT) ? STALL_MAX : BR_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0]    STALL_MAX_C = CW'(STALL_MAX);
  localparam logic [CW-1:0]    BR_LAST_C   = CW'(BR_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT_C   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DSTALL = 2'd1,
    BWAIT  = 2'd2
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [CW-1:0]   cnt_r, cnt_nxt_s;
  logic            pw_s, iw_s, fl_s, bb_s;
  logic            err_set_s, flush_inc_s;
  logic            stall_err_r;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

  // State and watchdog counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= RUN;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and Mealy control outputs; DSTALL without a hazard behaves as RUN.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    pw_s        = 1'b1;
    iw_s        = 1'b1;
    fl_s        = 1'b0;
    bb_s        = 1'b0;
    err_set_s   = 1'b0;
    flush_inc_s = 1'b0;
    case (state_r)
      BWAIT: begin
        fl_s = 1'b1;
        if (branch_resolved) begin
          state_nxt_s = RUN;
          cnt_nxt_s   = '0;
          flush_inc_s = branch_taken;
        end else if (cnt_r == BR_LAST_C) begin
          err_set_s   = 1'b1;
          state_nxt_s = RUN;
          cnt_nxt_s   = '0;
        end else begin
          pw_s      = 1'b0;
          cnt_nxt_s = cnt_r + CW'(1);
        end
      end
      RUN, DSTALL: begin
        if ((state_r == DSTALL) && data_hazard && (cnt_r < STALL_MAX_C)) begin
          pw_s      = 1'b0;
          iw_s      = 1'b0;
          bb_s      = 1'b1;
          cnt_nxt_s = cnt_r + CW'(1);
        end else if ((state_r == DSTALL) && data_hazard) begin
          err_set_s   = 1'b1;
          state_nxt_s = RUN;
          cnt_nxt_s   = '0;
        end else if (data_hazard) begin
          pw_s        = 1'b0;
          iw_s        = 1'b0;
          bb_s        = 1'b1;
          state_nxt_s = DSTALL;
          cnt_nxt_s   = CW'(1);
        end else if (control_hazard) begin
          pw_s        = 1'b0;
          fl_s        = 1'b1;
          state_nxt_s = BWAIT;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = RUN;
          cnt_nxt_s   = '0;
        end
      end
      default: begin
        state_nxt_s = RUN;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // Outputs are forced to the safe stall pattern while reset is held.
  always_comb begin
    if (!reset_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b1;
    end else begin
      pc_write    = pw_s;
      ifid_write  = iw_s;
      ifid_flush  = fl_s;
      idex_bubble = bb_s;
    end
  end

  // Sticky watchdog flag and saturating performance counters; clear beats increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_err_r <= 1'b0;
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      stall_err_r <= stall_err_r | err_set_s;
      if (clr_counters) begin
        stall_cnt_r <= '0;
        flush_cnt_r <= '0;
      end else begin
        if (!pw_s && (stall_cnt_r != CNT_SAT_C)) begin
          stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end
        if (flush_inc_s && (flush_cnt_r != CNT_SAT_C)) begin
          flush_cnt_r <= flush_cnt_r + CNT_W'(1);
        end
      end
    end
  end

  assign stall_error  = stall_err_r;
  assign stall_cycles = stall_cnt_r;
  assign flush_events = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller: default instance plus a
// CNT_W=4 instance sharing the same stimulus for the saturation case.
module tb_pipeline_stall_controller;

  logic clk;
  logic reset_n;
  logic data_hazard, control_hazard, branch_resolved, branch_taken, clr_counters;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, stall_error;
  logic [15:0] stall_cycles, flush_events;
  logic s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble, s_stall_error;
  logic [3:0] s_stall_cycles, s_flush_events;

  int checks   = 0;
  int failures = 0;

  localparam logic [3:0] NORM  = 4'b1100;
  localparam logic [3:0] STALL = 4'b0001;
  localparam logic [3:0] HOLD  = 4'b0110;
  localparam logic [3:0] RESV  = 4'b1110;
  localparam logic [3:0] RSTO  = 4'b0001;

  wire [3:0] ctl   = {pc_write, ifid_write, ifid_flush, idex_bubble};
  wire [3:0] s_ctl = {s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble};

  pipeline_stall_controller dut (
    .clk(clk), .reset_n(reset_n),
    .data_hazard(data_hazard), .control_hazard(control_hazard),
    .branch_resolved(branch_resolved), .branch_taken(branch_taken),
    .clr_counters(clr_counters),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .stall_error(stall_error),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  pipeline_stall_controller #(.STALL_MAX(4), .BR_TIMEOUT(8), .CNT_W(4)) dut_small (
    .clk(clk), .reset_n(reset_n),
    .data_hazard(data_hazard), .control_hazard(control_hazard),
    .branch_resolved(branch_resolved), .branch_taken(branch_taken),
    .clr_counters(clr_counters),
    .pc_write(s_pc_write), .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush),
    .idex_bubble(s_idex_bubble), .stall_error(s_stall_error),
    .stall_cycles(s_stall_cycles), .flush_events(s_flush_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic dh, input logic ch, input logic br,
                       input logic bt, input logic clr);
    data_hazard     = dh;
    control_hazard  = ch;
    branch_resolved = br;
    branch_taken    = bt;
    clr_counters    = clr;
    #2;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    data_hazard = 1'b0; control_hazard = 1'b0; branch_resolved = 1'b0;
    branch_taken = 1'b0; clr_counters = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", ctl, RSTO);
    chk("rst_small_ctl", s_ctl, RSTO);
    chk("rst_stall_cycles", stall_cycles, 0);
    chk("rst_flush_events", flush_events, 0);
    chk("rst_err", stall_error, 0);
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    chk("run_normal", ctl, NORM);
    tick;

    // Data stall of 2 cycles
    drive(1, 0, 0, 0, 0); chk("ds_c1", ctl, STALL); tick;
    drive(1, 0, 0, 0, 0); chk("ds_c2", ctl, STALL); tick;
    drive(0, 0, 0, 0, 0); chk("ds_c3", ctl, NORM);
    chk("ds_stall_cycles", stall_cycles, 2);
    tick;

    // Data watchdog: 4 stalls, forced release on the 5th, re-stall on the 6th
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, 0, 0);
      chk("wd_ctl", ctl, (i == 4) ? NORM : STALL);
      if (i == 4) chk("wd_err_pre", stall_error, 0);
      tick;
    end
    chk("wd_err", stall_error, 1);
    drive(0, 0, 0, 0, 0); chk("wd_release", ctl, NORM);
    chk("wd_stall_cycles", stall_cycles, 7);
    tick;

    // Reset asserted in the middle of BWAIT
    drive(0, 1, 0, 0, 0); chk("rb_entry", ctl, HOLD); tick;
    drive(0, 0, 0, 0, 0); chk("rb_bwait", ctl, HOLD);
    reset_n = 1'b0;
    #1;
    chk("rb_forced", ctl, RSTO);
    chk("rb_stall_cycles", stall_cycles, 0);
    chk("rb_err", stall_error, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 0); chk("rb_first_run", ctl, NORM); tick;
    chk("rb_no_count", stall_cycles, 0);

    // Taken branch resolved two cycles after entry
    drive(0, 1, 0, 0, 0); chk("tb_entry", ctl, HOLD); tick;
    drive(0, 0, 0, 0, 0); chk("tb_wait", ctl, HOLD); tick;
    drive(0, 0, 1, 1, 0); chk("tb_resolve", ctl, RESV); tick;
    drive(0, 0, 0, 0, 0); chk("tb_after", ctl, NORM);
    chk("tb_flush_events", flush_events, 1);
    chk("tb_stall_cycles", stall_cycles, 2);
    tick;

    // Not-taken branch resolved one cycle after entry
    drive(0, 1, 0, 0, 0); chk("nt_entry", ctl, HOLD); tick;
    drive(0, 0, 1, 0, 0); chk("nt_resolve", ctl, RESV); tick;
    drive(0, 0, 0, 0, 0);
    chk("nt_flush_events", flush_events, 1);
    chk("nt_stall_cycles", stall_cycles, 3);
    tick;

    // Spurious resolve in RUN
    drive(0, 0, 1, 1, 0); chk("sp_ctl", ctl, NORM); tick;
    drive(0, 0, 0, 0, 0);
    chk("sp_flush_events", flush_events, 1);
    tick;

    // Data beats control in RUN; DSTALL falls into BWAIT when data clears
    drive(1, 1, 0, 0, 0); chk("pr_data_first", ctl, STALL); tick;
    drive(0, 1, 0, 0, 0); chk("pr_to_bwait", ctl, HOLD); tick;
    drive(0, 0, 1, 1, 0); chk("pr_resolve", ctl, RESV); tick;
    drive(0, 0, 0, 0, 0);
    chk("pr_flush_events", flush_events, 2);
    chk("pr_stall_cycles", stall_cycles, 5);
    tick;

    // Branch watchdog with data hazard ignored in BWAIT
    drive(0, 1, 0, 0, 0); chk("bw_entry", ctl, HOLD); tick;
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, 0, 0);
      chk("bw_ctl", ctl, (i == 7) ? RESV : HOLD);
      tick;
    end
    chk("bw_err", stall_error, 1);
    drive(0, 0, 0, 0, 0); chk("bw_run", ctl, NORM);
    chk("bw_stall_cycles", stall_cycles, 13);
    tick;

    // Saturation with CNT_W=4, then clear during a stall cycle
    drive(0, 0, 0, 0, 1); tick;
    chk("cl_stall_cycles", stall_cycles, 0);
    chk("cl_flush_events", flush_events, 0);
    chk("cl_small_flush", s_flush_events, 0);
    for (int i = 0; i < 25; i++) begin
      drive(1, 0, 0, 0, 0);
      tick;
    end
    drive(0, 0, 0, 0, 0);
    chk("sat_big", stall_cycles, 20);
    chk("sat_small", s_stall_cycles, 15);
    chk("sat_small_err", s_stall_error, 1);
    tick;
    drive(1, 0, 0, 0, 1); chk("clr_stall_ctl", ctl, STALL); tick;
    chk("clr_big", stall_cycles, 0);
    chk("clr_small", s_stall_cycles, 0);
    drive(0, 0, 0, 0, 0); chk("clr_after", ctl, NORM);
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Sequences the pipeline-control response to the hazard detector in the five-stage MIPS pipeline. It turns the per-cycle `data_hazard` and `control_hazard` flags into PC-write, IF/ID-write, IF/ID-flush and ID/EX-bubble controls. It holds fetch until the EX stage resolves a branch, and guards both stall kinds with watchdogs. It also keeps saturating stall and flush performance counters.

## Interface
- `STALL_MAX`, default 4: maximum consecutive data-stall cycles before the watchdog forces release.
- `BR_TIMEOUT`, default 8: maximum cycles in branch wait without `branch_resolved`.
- `CNT_W`, default 16: width of the performance counters.

Clock is `clk`; reset is `reset_n`, asynchronous and active-low.

- `clk` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `data_hazard` input 1: hazard detector reports an RAW conflict in ID.
- `control_hazard` input 1: hazard detector reports a branch in ID.
- `branch_resolved` input 1: one-cycle pulse from EX when the branch outcome is known.
- `branch_taken` input 1: branch outcome; valid only while `branch_resolved`=1.
- `clr_counters` input 1: synchronous clear of both counters.
- `pc_write` output 1: PC register load enable.
- `ifid_write` output 1: IF/ID register load enable.
- `ifid_flush` output 1: load a NOP into IF/ID.
- `idex_bubble` output 1: load a NOP into ID/EX.
- `stall_error` output 1: sticky flag, set when either watchdog fires.
- `stall_cycles` output CNT_W: count of cycles with `pc_write`=0, excluding reset.
- `flush_events` output CNT_W: count of taken branches resolved.

## Operation
- States: RUN, DSTALL, BWAIT. Internal `cnt` is wide enough for max(STALL_MAX, BR_TIMEOUT).
- Outputs are Mealy on the current state and inputs. Priority in RUN and DSTALL: data_hazard > control_hazard > normal.
- **Normal outputs:** `pc_write`=1, `ifid_write`=1, `ifid_flush`=0, `idex_bubble`=0.
- **Data stall outputs:** `pc_write`=0, `ifid_write`=0, `idex_bubble`=1, `ifid_flush`=0.
- **Branch hold outputs:** `pc_write`=0, `ifid_write`=1, `ifid_flush`=1, `idex_bubble`=0.
  - The branch advances into EX.
  - The fetched instruction behind it is squashed.
- **RUN:**
  - `data_hazard`=1: data stall outputs; go to DSTALL with `cnt`=1.
  - `control_hazard`=1 (no data hazard): branch hold outputs; go to BWAIT with `cnt`=0.
  - Neither: normal outputs; stay in RUN.
- **DSTALL:**
  - `data_hazard`=1 and `cnt`<STALL_MAX: data stall outputs, `cnt`++.
  - `data_hazard`=1 and `cnt`==STALL_MAX: normal outputs, set `stall_error`, go to RUN.
  - `data_hazard`=0: behave exactly as RUN for the same inputs, including entry to BWAIT.
- **BWAIT:**
  - Outputs each cycle: `pc_write`=`branch_resolved`, `ifid_write`=1, `ifid_flush`=1, `idex_bubble`=0.
  - `data_hazard` and `control_hazard` are ignored, because ID holds a NOP.
  - On `branch_resolved`=1: go to RUN. The PC loads the target or fall-through via the datapath mux.
  - If `branch_taken`=1 at resolution, `flush_events`++.
  - `cnt` increments while unresolved. At `cnt`==BR_TIMEOUT-1 with no resolve: set `stall_error`, `pc_write`=1, go to RUN.
- **Spurious inputs:** `branch_resolved` in RUN or DSTALL is ignored and does not count.
- **Counters:**
  - `stall_cycles`++ on every non-reset cycle with `pc_write`=0.
  - Both counters saturate at 2^CNT_W-1.
  - `clr_counters` zeroes both on the next edge; clear wins over a simultaneous increment.
  - `stall_error` is cleared only by reset.

## Timing
- **During reset (`reset_n`=0), state and registers:**
  - State is RUN.
  - `cnt`, `stall_cycles`, `flush_events` and `stall_error` are 0.
- **During reset, outputs are forced:**
  - `pc_write`=0, `ifid_write`=0, `ifid_flush`=0, `idex_bubble`=1.
- **Reset mid-operation:** asynchronously aborts DSTALL or BWAIT. The first cycle after `reset_n` rises is in RUN.
- **Hazard response:** zero-cycle latency; stall and flush outputs respond in the same cycle the hazard flag is high.
- **Release:** `pc_write` returns high in the same cycle `data_hazard` falls or `branch_resolved` pulses.
- **Data-stall length:** a data hazard held N cycles (N≤STALL_MAX) produces exactly N cycles of data-stall outputs.
- **Branch hold length:** a branch resolved K cycles after entry (K≥1) produces K+1 cycles of `ifid_flush`=1, counting the RUN entry cycle.

## Test plan
- **Reset:** assert `reset_n`=0 mid-BWAIT. Required: outputs forced to their reset values at once; counters 0; the first cycle after release is in RUN with normal outputs.
- **Data stall:** hold `data_hazard` for 2 cycles, then 0. Required: 2 cycles of `pc_write`=0 and `idex_bubble`=1, normal outputs on the 3rd cycle, `stall_cycles`=2.
- **Data watchdog:** hold `data_hazard`=1 for 6 cycles with STALL_MAX=4. Required: 4 stall cycles, then normal outputs and `stall_error`=1 on cycle 5.
- **Taken branch:** pulse `control_hazard`, then `branch_resolved`=1 with `branch_taken`=1 two cycles later. Required: 3 cycles of `ifid_flush`=1, `pc_write`=1 on the resolve cycle, `flush_events`=1, `stall_cycles`=2.
- **Branch watchdog and ignored inputs:** assert `control_hazard`, then `data_hazard`=1 during BWAIT with no resolve. Required: the data hazard is ignored, and the timeout after 8 cycles sets `stall_error`.
- **Saturation and clear:** with CNT_W=4, drive 20 stall cycles. Required: `stall_cycles`=15. Then assert `clr_counters` in a stall cycle. Required: 0 on the next edge.
